// File: rtl/pu_spi_cycle_controller_if.sv
// Bus between the control unit / SPI PU and the cycle controller.
// master drives the requests and the raw chip select; slave is the controller.
interface pu_spi_cycle_controller_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 cycle_req;
    logic                 xfer_done;
    logic                 cs;
    logic                 err_clr;
    logic                 signal_cycle;
    logic                 cycle_hold;
    logic                 overrun;
    logic                 timeout;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic [CNT_WIDTH-1:0] xfer_count;

    modport master (
        output cycle_req, xfer_done, cs, err_clr,
        input  signal_cycle, cycle_hold, overrun, timeout, cycle_count, xfer_count
    );

    modport slave (
        input  cycle_req, xfer_done, cs, err_clr,
        output signal_cycle, cycle_hold, overrun, timeout, cycle_count, xfer_count
    );
endinterface

// File: rtl/pu_spi_cycle_controller.sv
// Pairs the control unit's end-of-program request with a finished SPI exchange
// and issues the one-clock signal_cycle pulse that swaps the PU double buffers.
module pu_spi_cycle_controller #(
    parameter int unsigned TIMEOUT       = 1000,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter bit          STRICT        = 1'b1
) (
    input logic                      clk,
    input logic                      rst,
    pu_spi_cycle_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        SWAP = 2'd3
    } state_e;

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

    state_e                   state_q, state_d;
    logic [1:0]               cs_sync_q;
    logic                     rst_ok_q;
    logic                     done_seen_q, done_seen_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                     overrun_q, overrun_d;
    logic                     timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]     cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0]     xfer_cnt_q, xfer_cnt_d;

    logic cs_idle;
    logic exchange_ready;
    logic set_ovr;
    logic set_tmo;

    // cs_sync_q[1] is the synchronised chip select; high means the master is idle.
    assign cs_idle        = cs_sync_q[1];
    assign exchange_ready = (done_seen_q || bus.xfer_done) && cs_idle;

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        set_ovr   = 1'b0;
        set_tmo   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cycle_req) state_d = SWAP;
            end
            RUN: begin
                if (bus.cycle_req) begin
                    if (exchange_ready) begin
                        state_d = SWAP;
                    end else if (!STRICT) begin
                        state_d = SWAP;
                        set_ovr = 1'b1;
                    end else begin
                        state_d   = WAIT;
                        tmo_cnt_d = '0;
                    end
                end
            end
            WAIT: begin
                if (exchange_ready) begin
                    state_d = SWAP;
                end else if (!cs_idle) begin
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = SWAP;
                    set_ovr = 1'b1;
                    set_tmo = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            SWAP: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completion landing on the swap edge belongs to the new period.
        done_seen_d = bus.xfer_done || (done_seen_q && (state_d != SWAP));

        overrun_d = set_ovr || (overrun_q && !bus.err_clr);
        timeout_d = set_tmo || (timeout_q && !bus.err_clr);

        cycle_cnt_d = cycle_cnt_q;
        if (state_q == SWAP) cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);

        xfer_cnt_d = xfer_cnt_q;
        if (bus.xfer_done) xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
    end

    // rst_ok_q holds the design still for the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cs_sync_q   <= 2'b11;
            rst_ok_q    <= 1'b0;
            done_seen_q <= 1'b0;
            tmo_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            cs_sync_q <= {cs_sync_q[0], bus.cs};
            rst_ok_q  <= 1'b1;
            if (rst_ok_q) begin
                state_q     <= state_d;
                done_seen_q <= done_seen_d;
                tmo_cnt_q   <= tmo_cnt_d;
                overrun_q   <= overrun_d;
                timeout_q   <= timeout_d;
                cycle_cnt_q <= cycle_cnt_d;
                xfer_cnt_q  <= xfer_cnt_d;
            end
        end
    end

    assign bus.signal_cycle = (state_q == SWAP);
    assign bus.cycle_hold   = (state_q == WAIT);
    assign bus.overrun      = overrun_q;
    assign bus.timeout      = timeout_q;
    assign bus.cycle_count  = cycle_cnt_q;
    assign bus.xfer_count   = xfer_cnt_q;

endmodule

// File: doc/pu_spi_cycle_controller.md
# pu_spi_cycle_controller

Cycle scheduler for the SPI slave processing unit. It decides when a new NITTA computational cycle may begin. It does this by pairing the control unit's end-of-program request with completion of the current SPI exchange, then issues the one-clock `signal_cycle` pulse that swaps the PU's double buffers. If no exchange completes, it stalls the control unit until the exchange completes or a master-absent timeout expires, and reports overrun and timeout conditions.

## Interface
Parameters:
- `TIMEOUT`, default 1000 — clocks of idle chip-select tolerated in WAIT before a forced swap; must be ≥ 1.
- `TIMEOUT_WIDTH`, default 16 — width of the timeout counter; must satisfy TIMEOUT < 2^TIMEOUT_WIDTH.
- `CNT_WIDTH`, default 16 — width of the cycle and transfer counters.
- `STRICT`, default 1 — selects the policy when no exchange has completed:
  - 1: stall in WAIT.
  - 0: swap immediately and flag overrun.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `cycle_req`  in  1  one-clock pulse from the control unit: computational program finished.
- `xfer_done`  in  1  one-clock pulse from the SPI PU `flag_stop`: SPI exchange finished.
- `cs`  in  1  raw SPI chip select, active-low; synchronised internally with 2 flops into `cs_s`.
- `err_clr`  in  1  one-clock pulse; clears the sticky error flags.
- `signal_cycle`  out  1  one-clock pulse to the SPI PU and the control unit: start a new cycle.
- `cycle_hold`  out  1  stall request to the control unit.
- `overrun`  out  1  sticky: a cycle started without a completed exchange.
- `timeout`  out  1  sticky: a swap was forced by timeout.
- `cycle_count`  out  CNT_WIDTH  number of `signal_cycle` pulses, wrapping.
- `xfer_count`  out  CNT_WIDTH  number of `xfer_done` pulses, wrapping.

## Operation
- State machine states: IDLE, RUN, WAIT, SWAP. All outputs are registered or decoded from the state register.
- `done_seen`: set by `xfer_done` in any state; cleared on entering SWAP, except when `xfer_done` is high in that same clock (then it stays set for the new period).
- `cs_idle` = `cs_s` == 1.
- IDLE: on `cycle_req`, go to SWAP. The first cycle needs no prior exchange and raises no overrun.
- RUN: on `cycle_req`, choose the first matching case:
  - `done_seen` && `cs_idle` → SWAP.
  - STRICT=0 → SWAP, set `overrun`.
  - Otherwise → WAIT, timeout counter cleared to 0.
- WAIT:
  - If (`done_seen` or `xfer_done`) && `cs_idle` → SWAP.
  - Else if `cs_s`=0 (transfer in progress): counter cleared, stay in WAIT.
  - Else counter increments. When counter == TIMEOUT-1 and increments → SWAP, set `timeout` and `overrun`.
- SWAP: lasts exactly one clock, then always goes to RUN. During it, `signal_cycle`=1 and `cycle_count` increments.
- `cycle_req` is ignored in WAIT and SWAP; it is not queued.
- `cycle_hold` = (state == WAIT).
- `xfer_count` increments on every `xfer_done`, in any state.
- `err_clr` clears `overrun` and `timeout`. If a set condition occurs in the same clock, the set wins.
- Counters wrap modulo 2^CNT_WIDTH with no flag.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state IDLE; `signal_cycle`=0, `cycle_hold`=0.
  - `overrun`=0, `timeout`=0, `cycle_count`=0, `xfer_count`=0.
  - `done_seen`=0, timeout counter=0, both sync flops=1 (idle).
- Deassertion of `rst` is taken synchronously: the first state transition happens at the second `clk` edge after release.
- Latency:
  - `cycle_req` at edge N with conditions met → `signal_cycle` high during cycle N+1.
  - `cs` change visible in `cs_idle` 2 clocks later.
- Reset mid-WAIT or mid-SWAP: `signal_cycle` drops immediately (asynchronous); no partial pulse is counted.
- `cycle_req` and `xfer_done` in the same RUN clock, with `cs_idle`: the request is treated as satisfied → SWAP next clock.
- Forced swap: `signal_cycle` occurs exactly TIMEOUT clocks of continuous `cs_idle` after WAIT entry, or after the last `cs_s` low.

## Test plan
- Reset, then `cycle_req` → `signal_cycle` pulse 1 clock later, `cycle_count`=1, `overrun`=0.
- RUN, pulse `xfer_done` with `cs` high, then `cycle_req` 5 clocks later → SWAP next clock; `done_seen` cleared; `xfer_count`=1.
- STRICT=1, TIMEOUT=8: `cycle_req` with no exchange → `cycle_hold`=1. `cs` low for 3 clocks then high, no `xfer_done` → `signal_cycle` 8 clocks after `cs_s` returns high; `timeout`=1, `overrun`=1.
- STRICT=1: `cycle_req` with no exchange, then `xfer_done` while `cs` high → `cycle_hold` drops, `signal_cycle` next clock, `overrun`=0.
- STRICT=0: `cycle_req` with no exchange → immediate swap, `overrun`=1. Then `err_clr` → `overrun`=0. `err_clr` coincident with a new overrun → `overrun` stays 1.
- CNT_WIDTH=4: 17 swaps → `cycle_count`=1. Assert `rst` during WAIT → all outputs return to reset values within the same clock.
